wb_trace_buffer: RTL

- Sink on the processor's register-writeback interface (write address, write data, plus a write enable).
- Each qualifying writeback becomes a trace record {cycle stamp, address, data} queued in an internal FIFO.
- Records drain through a valid/ready port to a bench checker or debug readout, so writeback logging no longer relies on per-cycle monitoring.
- Overflow is counted, never silent.

---
 rtl/wb_trace_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: stamps each qualifying register writeback and queues
// {stamp, addr, data} in a first-word-fall-through FIFO with overflow accounting.
module wb_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int STAMP_W   = 16,
  parameter int DEPTH     = 8,
  parameter int IGNORE_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [STAMP_W-1:0]       out_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = STAMP_W + ADDR_W + DATA_W;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [REC_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;
  logic               valid_q, valid_d;
  logic [REC_W-1:0]   head_q, head_d;

  logic               cap, pop, push, drop, full;
  logic [CNT_W-1:0]   live;
  logic [REC_W-1:0]   rec_in;

  assign cap    = wb_en && !((IGNORE_R0 != 0) && (wb_addr == '0));
  assign pop    = valid_q && out_ready;
  assign full   = (count_q == CNT_W'(DEPTH));
  assign push   = cap && (!full || pop);
  assign drop   = cap && full && !pop;
  assign live   = count_q - CNT_W'(pop);
  assign rec_in = {stamp_q, wb_addr, wb_data};

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    stamp_d    = stamp_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    valid_d    = valid_q;
    head_d     = head_q;
    if (clear) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      stamp_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
      valid_d    = 1'b0;
    end else begin
      stamp_d = stamp_q + STAMP_W'(1);
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        drop_d     = sat_inc8(drop_q);
      end
      valid_d = (count_d != '0);
      // The new record becomes the head only when nothing older survives this edge.
      if (push && (live == '0)) begin
        head_d = rec_in;
      end else if (count_d != '0) begin
        head_d = mem_q[rptr_d];
      end
    end
  end

  // ---- storage stage: record RAM, no reset needed ----
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wptr_q] <= rec_in;
    end
  end

  // ---- control and head-register stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      stamp_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      stamp_q    <= stamp_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_stamp  = head_q[REC_W-1 -: STAMP_W];
  assign out_addr   = head_q[DATA_W +: ADDR_W];
  assign out_data   = head_q[DATA_W-1:0];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule
